// File: rtl/stream_ser_pkg.sv
// Shared types and geometry helpers for the stream tree serializer.
// WIDTH/LANES derive the beats per word and the beat counter width.
package stream_ser_pkg;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } sh_state_e;

    function automatic int unsigned calc_steps(int unsigned width, int unsigned lanes);
        return width / lanes;
    endfunction

    function automatic int unsigned calc_cntw(int unsigned width, int unsigned lanes);
        int unsigned steps;
        steps = width / lanes;
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic bit geometry_ok(int unsigned width, int unsigned lanes);
        return (lanes >= 1) && (lanes <= width) && ((width % lanes) == 0);
    endfunction

endpackage

// File: rtl/stream_tree_serializer_if.sv
// Producer-side handshake and serial-link outputs of the stream tree serializer.
// Signal names are from the serializer's point of view.
interface stream_tree_serializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             msb_first_i;
    logic             ready_o;
    logic [LANES-1:0] data_o;
    logic             valid_o;
    logic             sof_o;

    modport master (
        output data_i, valid_i, msb_first_i,
        input  ready_o, data_o, valid_o, sof_o
    );

    modport slave (
        input  data_i, valid_i, msb_first_i,
        output ready_o, data_o, valid_o, sof_o
    );
endinterface

// File: rtl/ser_beat_select.sv
// Picks the LANES-bit beat for the current counter value from the shifter word,
// in either bit order.
module ser_beat_select
    import stream_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1,
    localparam int unsigned STEPS = calc_steps(WIDTH, LANES),
    localparam int unsigned CNTW  = calc_cntw(WIDTH, LANES)
) (
    input  logic [WIDTH-1:0] sh_data_i,
    input  logic [CNTW-1:0]  cnt_i,
    input  bit_order_e       order_i,
    output logic [LANES-1:0] beat_o
);

    always_comb begin
        beat_o = '0;
        for (int unsigned s = 0; s < STEPS; s++) begin
            if (cnt_i == CNTW'(s)) begin
                if (order_i == MSB_FIRST) begin
                    beat_o = sh_data_i[WIDTH-1-s*LANES -: LANES];
                end else begin
                    beat_o = sh_data_i[s*LANES +: LANES];
                end
            end
        end
    end

endmodule

// File: rtl/stream_tree_serializer.sv
// Single-clock serializer: a one-word holding buffer feeds a beat-counted shifter
// whose current beat is captured into registered outputs every cycle.
module stream_tree_serializer
    import stream_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    stream_tree_serializer_if.slave   bus
);

    localparam int unsigned STEPS = calc_steps(WIDTH, LANES);
    localparam int unsigned CNTW  = calc_cntw(WIDTH, LANES);
    localparam logic [CNTW-1:0] LastCnt = CNTW'(STEPS - 1);

    if (!geometry_ok(WIDTH, LANES)) begin : g_bad_geometry
        $error("stream_tree_serializer: WIDTH must be a non-zero multiple of LANES");
    end

    sh_state_e        state_q, state_d;
    logic [WIDTH-1:0] sh_data_q, sh_data_d;
    bit_order_e       sh_order_q, sh_order_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hb_data_q, hb_data_d;
    bit_order_e       hb_order_q, hb_order_d;
    logic             hb_valid_q, hb_valid_d;
    logic             ready_q, ready_d;
    logic [LANES-1:0] dout_q, dout_d;
    logic             vout_q, vout_d;
    logic             sof_q, sof_d;

    logic [LANES-1:0] beat;
    logic             accept;
    logic             sh_free;
    bit_order_e       in_order;

    ser_beat_select #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_beat_select (
        .sh_data_i (sh_data_q),
        .cnt_i     (cnt_q),
        .order_i   (sh_order_q),
        .beat_o    (beat)
    );

    assign in_order = bus.msb_first_i ? MSB_FIRST : LSB_FIRST;
    assign accept   = bus.valid_i && ready_q;
    // Free also on the last beat, so the next word follows with no bubble.
    assign sh_free  = (state_q == StIdle) || (cnt_q == LastCnt);

    always_comb begin
        state_d    = state_q;
        sh_data_d  = sh_data_q;
        sh_order_d = sh_order_q;
        cnt_d      = cnt_q;
        hb_data_d  = hb_data_q;
        hb_order_d = hb_order_q;
        hb_valid_d = hb_valid_q;

        if (state_q == StShift) begin
            dout_d = beat;
            vout_d = 1'b1;
            sof_d  = (cnt_q == '0);
        end else begin
            dout_d = '0;
            vout_d = 1'b0;
            sof_d  = 1'b0;
        end

        if (sh_free) begin
            cnt_d = '0;
            if (hb_valid_q) begin
                state_d    = StShift;
                sh_data_d  = hb_data_q;
                sh_order_d = hb_order_q;
                hb_valid_d = 1'b0;
            end else if (accept) begin
                state_d    = StShift;
                sh_data_d  = bus.data_i;
                sh_order_d = in_order;
            end else begin
                state_d = StIdle;
            end
        end else begin
            cnt_d = cnt_q + CNTW'(1);
            if (accept) begin
                hb_data_d  = bus.data_i;
                hb_order_d = in_order;
                hb_valid_d = 1'b1;
            end
        end

        ready_d = !hb_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sh_data_q  <= '0;
            sh_order_q <= LSB_FIRST;
            cnt_q      <= '0;
            hb_data_q  <= '0;
            hb_order_q <= LSB_FIRST;
            hb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            dout_q     <= '0;
            vout_q     <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_data_q  <= sh_data_d;
            sh_order_q <= sh_order_d;
            cnt_q      <= cnt_d;
            hb_data_q  <= hb_data_d;
            hb_order_q <= hb_order_d;
            hb_valid_q <= hb_valid_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            vout_q     <= vout_d;
            sof_q      <= sof_d;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.data_o  = dout_q;
    assign bus.valid_o = vout_q;
    assign bus.sof_o   = sof_q;

endmodule

// File: tb/tb_stream_tree_serializer.sv
// Directed and scoreboard checks of the serializer in 8x2 and 8x8 geometry,
// plus the beat selector on its own.
module tb_stream_tree_serializer;
    import stream_ser_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    stream_tree_serializer_if #(.WIDTH(8), .LANES(2)) bus_a ();
    stream_tree_serializer_if #(.WIDTH(8), .LANES(8)) bus_b ();

    stream_tree_serializer #(.WIDTH(8), .LANES(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    stream_tree_serializer #(.WIDTH(8), .LANES(8)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    logic [7:0] sel_data;
    logic [1:0] sel_cnt;
    bit_order_e sel_order;
    logic [1:0] sel_beat;

    ser_beat_select #(.WIDTH(8), .LANES(2)) u_sel (
        .sh_data_i (sel_data),
        .cnt_i     (sel_cnt),
        .order_i   (sel_order),
        .beat_o    (sel_beat)
    );

    typedef struct packed {
        logic [7:0]      data;
        logic            msb;
        logic [3:0][1:0] beats;  // listed beat3..beat0
    } vec_t;

    vec_t       vecs [6];
    logic [1:0] bb_exp [12];
    logic       exp_rdy [9];
    logic [7:0] bb_words [3];
    logic [2:0] sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check();
        logic [2:0] e;
        if (bus_a.valid_o) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_beat", 32'(bus_a.valid_o), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("sb_beat", 32'({bus_a.sof_o, bus_a.data_o}), 32'(e));
            end
        end
    endtask

    initial begin
        int         idx;
        int         sent;
        int         cyc;
        logic       rdy;
        logic [1:0] bt;

        checks   = 0;
        failures = 0;

        vecs[0] = '{data: 8'hB4, msb: 1'b0, beats: {2'b10, 2'b11, 2'b01, 2'b00}};
        vecs[1] = '{data: 8'hB4, msb: 1'b1, beats: {2'b00, 2'b01, 2'b11, 2'b10}};
        vecs[2] = '{data: 8'h5A, msb: 1'b0, beats: {2'b01, 2'b01, 2'b10, 2'b10}};
        vecs[3] = '{data: 8'h5A, msb: 1'b1, beats: {2'b10, 2'b10, 2'b01, 2'b01}};
        vecs[4] = '{data: 8'hC3, msb: 1'b1, beats: {2'b11, 2'b00, 2'b00, 2'b11}};
        vecs[5] = '{data: 8'h1E, msb: 1'b0, beats: {2'b00, 2'b01, 2'b11, 2'b10}};

        bb_exp   = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01,
                     2'b11, 2'b11, 2'b11, 2'b11};
        exp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bb_words = '{8'hB4, 8'h5A, 8'hFF};

        bus_a.valid_i = 1'b0; bus_a.data_i = '0; bus_a.msb_first_i = 1'b0;
        bus_b.valid_i = 1'b0; bus_b.data_i = '0; bus_b.msb_first_i = 1'b0;

        // Beat selector alone.
        sel_data = 8'hB4; sel_cnt = 2'd2; sel_order = LSB_FIRST; #1;
        check("sel_lsb_c2", 32'(sel_beat), 32'(2'b11));
        sel_order = MSB_FIRST; #1;
        check("sel_msb_c2", 32'(sel_beat), 32'(2'b01));
        sel_cnt = 2'd0; #1;
        check("sel_msb_c0", 32'(sel_beat), 32'(2'b10));
        sel_cnt = 2'd3; sel_order = LSB_FIRST; #1;
        check("sel_lsb_c3", 32'(sel_beat), 32'(2'b10));
        sel_data = 8'h5A; sel_cnt = 2'd1; #1;
        check("sel_lsb_5a_c1", 32'(sel_beat), 32'(2'b10));

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        check("rst_data", 32'(bus_a.data_o), 32'(0));
        check("rst_valid", 32'(bus_a.valid_o), 32'(0));
        check("rst_sof", 32'(bus_a.sof_o), 32'(0));
        check("rst_ready", 32'(bus_a.ready_o), 32'(1));
        check("rst_ready_b", 32'(bus_b.ready_o), 32'(1));
        check("rst_valid_b", 32'(bus_b.valid_o), 32'(0));
        reset = 1'b0;
        tick();

        // Single words from the table; bit order flips after accept to show it is latched.
        for (int v = 0; v < 6; v++) begin
            check("vec_ready", 32'(bus_a.ready_o), 32'(1));
            bus_a.data_i      = vecs[v].data;
            bus_a.msb_first_i = vecs[v].msb;
            bus_a.valid_i     = 1'b1;
            tick();
            bus_a.valid_i     = 1'b0;
            bus_a.msb_first_i = ~vecs[v].msb;
            for (int b = 0; b < 4; b++) begin
                tick();
                check("vec_data", 32'(bus_a.data_o), 32'(vecs[v].beats[b]));
                check("vec_sof", 32'(bus_a.sof_o), 32'(b == 0));
                check("vec_valid", 32'(bus_a.valid_o), 32'(1));
            end
            tick();
            check("vec_idle_valid", 32'(bus_a.valid_o), 32'(0));
            check("vec_idle_data", 32'(bus_a.data_o), 32'(0));
        end

        // Back-to-back words with valid held high.
        idx = 0;
        bus_a.data_i      = bb_words[0];
        bus_a.msb_first_i = 1'b0;
        bus_a.valid_i     = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rdy = bus_a.ready_o;
            tick();
            if (rdy && bus_a.valid_i) begin
                idx++;
                if (idx == 3) bus_a.valid_i = 1'b0;
                else bus_a.data_i = bb_words[idx];
            end
            if (c <= 8) check("bb_ready", 32'(bus_a.ready_o), 32'(exp_rdy[c]));
            if (c >= 1 && c <= 12) begin
                check("bb_valid", 32'(bus_a.valid_o), 32'(1));
                check("bb_sof", 32'(bus_a.sof_o), 32'(((c - 1) % 4) == 0));
                check("bb_data", 32'(bus_a.data_o), 32'(bb_exp[c-1]));
            end
            if (c >= 13) check("bb_tail_valid", 32'(bus_a.valid_o), 32'(0));
        end
        check("bb_words_taken", 32'(idx), 32'(3));

        // Reset mid-word with the holding buffer full.
        bus_a.data_i = 8'hB4; bus_a.msb_first_i = 1'b0; bus_a.valid_i = 1'b1;
        tick();
        bus_a.data_i = 8'h5A;
        tick();
        bus_a.valid_i = 1'b0;
        tick();
        tick();
        check("rstmid_beat2", 32'(bus_a.data_o), 32'(2'b11));
        check("rstmid_hb_full", 32'(bus_a.ready_o), 32'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_valid", 32'(bus_a.valid_o), 32'(0));
        check("rstmid_data", 32'(bus_a.data_o), 32'(0));
        check("rstmid_sof", 32'(bus_a.sof_o), 32'(0));
        check("rstmid_ready", 32'(bus_a.ready_o), 32'(1));
        for (int c = 0; c < 8; c++) begin
            tick();
            check("rstmid_no_stale", 32'(bus_a.valid_o), 32'(0));
        end

        // WIDTH=LANES: two-stage pipeline, every beat is a start of word.
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                bus_b.valid_i = 1'b1;
                bus_b.data_i  = 8'(c + 1);
            end else begin
                bus_b.valid_i = 1'b0;
            end
            tick();
            check("p8_ready", 32'(bus_b.ready_o), 32'(1));
            if (c >= 1 && c <= 16) begin
                check("p8_data", 32'(bus_b.data_o), 32'(c));
                check("p8_valid", 32'(bus_b.valid_o), 32'(1));
                check("p8_sof", 32'(bus_b.sof_o), 32'(1));
            end
        end
        tick();
        check("p8_idle", 32'(bus_b.valid_o), 32'(0));

        // Throttled random stream against a scoreboard.
        sent = 0;
        cyc  = 0;
        bus_a.valid_i = 1'b0;
        while (sent < 10000 && cyc < 80000) begin
            if (!bus_a.valid_i && $urandom_range(3) != 0) begin
                bus_a.valid_i     = 1'b1;
                bus_a.data_i      = 8'($urandom);
                bus_a.msb_first_i = 1'($urandom);
            end
            rdy = bus_a.ready_o;
            tick();
            cyc++;
            if (rdy && bus_a.valid_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus_a.msb_first_i) bt = bus_a.data_i[7-2*b -: 2];
                    else bt = bus_a.data_i[2*b +: 2];
                    sb_q.push_back({(b == 0), bt});
                end
                sent++;
                bus_a.valid_i = 1'b0;
            end
            sb_check();
        end
        bus_a.valid_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            sb_check();
        end
        check("sb_words_sent", 32'(sent), 32'(10000));
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_tree_serializer.md
Name: stream_tree_serializer

Overview:
Parametrised successor to the divided-clock tree serializer. It runs on one clock and uses a beat counter instead of a clock-divider chain. Serializes WIDTH-bit parallel words onto LANES output bits per cycle, with a valid/ready input handshake, a one-word holding buffer for gapless back-to-back words, per-word bit-order selection and a start-of-word marker. Sits between a parallel datapath producer and the serial link driver; all outputs are registered.

Parameters:
WIDTH, 16, parallel input word width; must be a multiple of LANES and ≥ LANES.
LANES, 1, serial output bits per cycle; must be 1..WIDTH.
STEPS, WIDTH/LANES, derived localparam: beats per word; never overridden.
CNTW, max(1,$clog2(STEPS)), derived localparam: beat counter width.

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset; sampled on rising clk.
data_i  input  WIDTH  parallel word; valid only while valid_i=1.
valid_i  input  1  producer offers data_i.
msb_first_i  input  1  bit order for the offered word (1 = MSB-first); sampled with data_i.
ready_o  output  1  block can accept a word this cycle.
data_o  output  LANES  registered serial beat.
valid_o  output  1  data_o carries a beat.
sof_o  output  1  high on beat 0 of each word.

Behaviour:
- Reset: synchronous and active-high, and it takes priority over all other events. Clears the holding buffer, the shifter and the counter. On the next edge: data_o=0, valid_o=0, sof_o=0, ready_o=1. Words in flight are discarded with no partial output after the reset edge.
- Handshake: a word is accepted on an edge where valid_i&&ready_o=1. ready_o = !hb_valid, decoded from registered state with no combinational path from valid_i. Holding data_i stable while ready_o=0 is the producer's obligation and is not checked.
- State: shifter (sh_data WIDTH, sh_msb, sh_busy, cnt CNTW) plus holding buffer (hb_data, hb_msb, hb_valid). Shifter states: IDLE (sh_busy=0) and SHIFT (sh_busy=1, cnt 0..STEPS-1).
- "Shifter free" = IDLE, or SHIFT with cnt==STEPS-1 (last beat issued this edge).
- Accept while shifter free and hb_valid=0: the word loads the shifter directly (cnt=0, SHIFT).
- Accept while shifter not free: the word goes to the holding buffer (hb_valid=1).
- Shifter free with hb_valid=1: the shifter loads from the holding buffer and hb_valid clears on the same edge. No accept can coincide, because ready_o=0.
- Beat selection: LSB-first emits sh_data[(cnt+1)*LANES-1 : cnt*LANES]. MSB-first emits sh_data[WIDTH-1-cnt*LANES -: LANES], with the lane MSB taken from the higher word bit.
- Output register: each SHIFT cycle captures the current beat into data_o, sets valid_o=1 and sets sof_o=(cnt==0). In IDLE, data_o=0, valid_o=0, sof_o=0.
- Latency: word accepted at edge k with the shifter free: beat 0 is visible after edge k+1, and beat STEPS-1 after edge k+STEPS.
- Throughput: one word per STEPS cycles with no idle beat between consecutive words, provided the producer keeps valid_i high.
- Counter wrap: cnt increments in SHIFT. At STEPS-1 it wraps to 0 on reload, or the shifter goes IDLE when there is nothing to reload.
- STEPS=1 (LANES=WIDTH): cnt is constant 0, every SHIFT cycle is a last beat, and the block acts as a 2-deep registered pipeline with sof_o=valid_o.
- Bit order is latched per word. Changing msb_first_i mid-word does not affect a word already accepted.

Decomposition:
- Package stream_ser_pkg: a function computing STEPS and CNTW from WIDTH/LANES; an elaboration-time check that WIDTH%LANES==0; a bit-order enum {LSB_FIRST, MSB_FIRST}.
- One sub-module, ser_beat_select: combinational mux (sh_data, cnt, msb) -> LANES-bit beat. Both bit orders are tested in isolation.
- Top level holds the holding buffer, shifter, counter, control and output register.

Test Plan:
- WIDTH=8, LANES=2: data_i=0xB4, msb_first_i=0, single accept. Required after edges k+1..k+4: data_o=00,01,11,10; sof_o=1,0,0,0; valid_o=1 for 4 cycles, then 0.
- Same word with msb_first_i=1. Required: data_o=10,11,01,00.
- Back-to-back 0xB4, 0x5A, 0xFF with valid_i held high. Required: 12 consecutive valid beats, sof_o every 4th, and ready_o low exactly while hb_valid=1.
- Assert reset during beat 2 of 0xB4 with a word in the holding buffer. Required: valid_o=0, data_o=0, ready_o=1 after the reset edge, and no stale beats afterwards.
- WIDTH=LANES=8: stream 0x01..0x10 continuously. Required: data_o mirrors the input delayed 2 cycles, and valid_o=sof_o=1 every cycle.
- Random valid_i throttling against a scoreboard model, 10k words, randomized bit order. Required: zero data mismatches.
